sdram_port_arbiter: RTL

Shares the single 8-bit SDRAM controller port between three requesters: the ROM/tape download writer (ioctl path), the cassette playback reader and the cartridge ROM reader. It sequences one access at a time into the controller's addr/din/rd/we interface and waits for completion. It returns read data and a valid strobe to the requester that issued the read. It sits between hps_io/cassette/cartridge logic and the sdram controller, all on clk_sys.

---
 rtl/sdram_port_arbiter_if.sv | 52 +++++
 rtl/sdram_port_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - Requester and SDRAM-controller signals shared by the port arbiter
interface sdram_port_arbiter_if #(
  parameter int AW = 25,
  parameter int DW = 8
);
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_full;
  logic          wr_overrun;

  logic          rd0_req;
  logic [AW-1:0] rd0_addr;
  logic [DW-1:0] rd0_data;
  logic          rd0_valid;

  logic          rd1_req;
  logic [AW-1:0] rd1_addr;
  logic [DW-1:0] rd1_data;
  logic          rd1_valid;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic          mem_rd;
  logic [DW-1:0] mem_dout;
  logic          mem_ready;

  // Arbiter side
  modport slave (
    input  wr_strobe, wr_addr, wr_data,
    output wr_full, wr_overrun,
    input  rd0_req, rd0_addr,
    output rd0_data, rd0_valid,
    input  rd1_req, rd1_addr,
    output rd1_data, rd1_valid,
    output mem_addr, mem_din, mem_we, mem_rd,
    input  mem_dout, mem_ready
  );

  // Requesters plus SDRAM controller side
  modport master (
    output wr_strobe, wr_addr, wr_data,
    input  wr_full, wr_overrun,
    output rd0_req, rd0_addr,
    input  rd0_data, rd0_valid,
    output rd1_req, rd1_addr,
    input  rd1_data, rd1_valid,
    input  mem_addr, mem_din, mem_we, mem_rd,
    output mem_dout, mem_ready
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - Shares one SDRAM controller port between the download writer and two readers
module sdram_port_arbiter #(
  parameter int AW         = 25,
  parameter int DW         = 8,
  parameter bit USE_READY  = 1'b1,
  parameter int FIXED_WAIT = 6
) (
  input  logic                clk,
  input  logic                reset,
  sdram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;
  typedef enum logic [1:0] {GNT_WR, GNT_RD0, GNT_RD1} gnt_t;

  localparam int CW = (FIXED_WAIT > 1) ? $clog2(FIXED_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(FIXED_WAIT - 1);

  state_t        state, state_nxt;
  gnt_t          gnt, gnt_nxt;
  logic          grant_any;
  logic          rr_ptr;
  logic [CW-1:0] wait_cnt;
  logic          ready_q;
  logic [DW-1:0] dout_buf;
  logic          complete;
  logic [DW-1:0] rd_word;

  logic          wr_full_q;
  logic          wr_overrun_q;
  logic [AW-1:0] wr_buf_addr;
  logic [DW-1:0] wr_buf_data;
  logic          wr_done;
  logic          wr_accept;

  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic [DW-1:0] rd0_data_q;
  logic [DW-1:0] rd1_data_q;

  // mem_ready is registered before use, so handshake completion lands one cycle after it
  assign complete = USE_READY ? ready_q : (wait_cnt == '0);
  assign rd_word  = USE_READY ? dout_buf : bus.mem_dout;

  assign wr_done   = (state == DONE) && (gnt == GNT_WR);
  assign wr_accept = bus.wr_strobe && (!wr_full_q || wr_done);

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    grant_any = 1'b0;
    case (state)
      IDLE: begin
        // A strobe arriving in IDLE is granted straight away while it is also buffered
        if (wr_full_q || bus.wr_strobe) begin
          gnt_nxt   = GNT_WR;
          grant_any = 1'b1;
        end else if (bus.rd0_req && (!rr_ptr || !bus.rd1_req)) begin
          gnt_nxt   = GNT_RD0;
          grant_any = 1'b1;
        end else if (bus.rd1_req) begin
          gnt_nxt   = GNT_RD1;
          grant_any = 1'b1;
        end
        if (grant_any) begin
          state_nxt = CMD;
        end
      end
      CMD:  state_nxt = WAIT;
      WAIT: if (complete) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      gnt          <= GNT_RD0;
      rr_ptr       <= 1'b0;
      wait_cnt     <= '0;
      ready_q      <= 1'b0;
      dout_buf     <= '0;
      wr_full_q    <= 1'b0;
      wr_overrun_q <= 1'b0;
      wr_buf_addr  <= '0;
      wr_buf_data  <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      rd0_data_q   <= '0;
      rd1_data_q   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;

      if ((state == IDLE) && grant_any) begin
        case (gnt_nxt)
          GNT_WR: begin
            addr_q <= wr_full_q ? wr_buf_addr : bus.wr_addr;
            din_q  <= wr_full_q ? wr_buf_data : bus.wr_data;
          end
          GNT_RD0: addr_q <= bus.rd0_addr;
          default: addr_q <= bus.rd1_addr;
        endcase
      end

      if (state == CMD) begin
        wait_cnt <= WAIT_LOAD;
      end else if ((state == WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - CW'(1);
      end

      ready_q <= (state == WAIT) && bus.mem_ready && !ready_q;
      if ((state == WAIT) && bus.mem_ready && !ready_q) begin
        dout_buf <= bus.mem_dout;
      end

      if ((state == WAIT) && complete && (gnt == GNT_RD0)) begin
        rd0_data_q <= rd_word;
      end
      if ((state == WAIT) && complete && (gnt == GNT_RD1)) begin
        rd1_data_q <= rd_word;
      end

      // After serving one reader the other one gets priority
      if ((state == DONE) && (gnt != GNT_WR)) begin
        rr_ptr <= (gnt == GNT_RD0);
      end

      if (wr_accept) begin
        wr_full_q   <= 1'b1;
        wr_buf_addr <= bus.wr_addr;
        wr_buf_data <= bus.wr_data;
      end else if (wr_done) begin
        wr_full_q <= 1'b0;
      end
      if (bus.wr_strobe && !wr_accept) begin
        wr_overrun_q <= 1'b1;
      end
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_din    = din_q;
  assign bus.mem_we     = (state == CMD) && (gnt == GNT_WR);
  assign bus.mem_rd     = (state == CMD) && (gnt != GNT_WR);
  assign bus.rd0_valid  = (state == DONE) && (gnt == GNT_RD0);
  assign bus.rd1_valid  = (state == DONE) && (gnt == GNT_RD1);
  assign bus.rd0_data   = rd0_data_q;
  assign bus.rd1_data   = rd1_data_q;
  assign bus.wr_full    = wr_full_q;
  assign bus.wr_overrun = wr_overrun_q;
endmodule
